// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: request/status handshake and PS/2 pad signals of the host transmitter
//   wr_ps2/din            : send request and command byte (master -> slave)
//   ps2c_in/ps2d_in       : sensed pad levels (master -> slave)
//   ps2c_oe/ps2d_oe       : open-drain pull-low enables (slave -> master)
//   tx_idle/tx_done_tick/tx_err : transmitter status (slave -> master)
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;
    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err
    );
    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte per request
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : ps2_host_tx_if.slave (wr_ps2, din, ps2c_in, ps2d_in in; ps2c_oe, ps2d_oe,
//           tx_idle, tx_done_tick, tx_err out)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic         clk,
    input logic         reset,
    ps2_host_tx_if.slave bus
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK, WAIT_IDLE, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
    logic                  filt_q, filt_d, fall, timeout;
    logic [8:0]            frame_q, frame_d;
    logic [3:0]            bit_q, bit_d;
    logic [IW-1:0]         inh_q, inh_d;
    logic [TW-1:0]         to_q, to_d;
    logic                  err_q, err_d;
    logic                  c_oe_q, c_oe_d, d_oe_q, d_oe_d;
    logic                  idle_q, idle_d, done_q, done_d, tx_err_q, tx_err_d;

    always_comb begin
        c_sync_d  = {c_sync_q[0], bus.ps2c_in};
        d_sync_d  = {d_sync_q[0], bus.ps2d_in};
        filt_sh_d = {filt_sh_q[FILTER_LEN-2:0], c_sync_q[1]};
        // level only changes once the whole window agrees, so short glitches are absorbed
        filt_d    = (&filt_sh_q) ? 1'b1 : (~|filt_sh_q) ? 1'b0 : filt_q;
        fall      = filt_q & ~filt_d;
        timeout   = !fall && to_q == TW'(TIMEOUT_CYCLES - 1);
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        inh_d     = inh_q;
        err_d     = err_q;
        to_d      = fall ? '0 : to_q + 1'b1;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (bus.wr_ps2) begin
                    frame_d = {~^bus.din, bus.din};
                    bit_d   = '0;
                    inh_d   = '0;
                    err_d   = 1'b0;
                    state_d = RTS;
                end
            end
            RTS: begin
                to_d  = '0;
                inh_d = inh_q + 1'b1;
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) state_d = START;
            end
            START: if (fall) state_d = DATA;
            DATA: if (fall) begin
                frame_d = frame_q >> 1;
                bit_d   = bit_q + 1'b1;
                if (bit_q == 4'd8) state_d = STOP;
            end
            STOP: if (fall) state_d = ACK;
            ACK: if (fall) begin
                err_d   = d_sync_q[1];
                state_d = WAIT_IDLE;
            end
            WAIT_IDLE: if (filt_q && d_sync_q[1]) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (timeout && state_q inside {START, DATA, STOP, ACK, WAIT_IDLE}) begin
            err_d   = 1'b1;
            state_d = DONE;
        end
        // outputs are decoded from the next state so they leave the flops glitch-free
        c_oe_d   = state_d == RTS;
        d_oe_d   = state_d == START || (state_d == DATA && !frame_d[0]);
        idle_d   = state_d == IDLE;
        done_d   = state_d == DONE;
        tx_err_d = state_d == DONE && err_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            c_sync_q  <= '1;
            d_sync_q  <= '1;
            filt_sh_q <= '1;
            filt_q    <= 1'b1;
            frame_q   <= '0;
            bit_q     <= '0;
            inh_q     <= '0;
            to_q      <= '0;
            err_q     <= 1'b0;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_sync_q  <= c_sync_d;
            d_sync_q  <= d_sync_d;
            filt_sh_q <= filt_sh_d;
            filt_q    <= filt_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            err_q     <= err_d;
            c_oe_q    <= c_oe_d;
            d_oe_q    <= d_oe_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            tx_err_q  <= tx_err_d;
        end
    end

    assign bus.ps2c_oe      = c_oe_q;
    assign bus.ps2d_oe      = d_oe_q;
    assign bus.tx_idle      = idle_q;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_err       = tx_err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model and a cycle-by-cycle status checker
`timescale 1ns/1ps
module tb_ps2_host_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dev_c = 1'b1;
    logic dev_d = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();
    assign bus.ps2c_in = dev_c & ~bus.ps2c_oe;
    assign bus.ps2d_in = dev_d & ~bus.ps2d_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(50), .FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        exp_busy = 1'b0;
    logic        exp_end_ok = 1'b0;
    logic        exp_err = 1'b0;
    logic [10:0] samp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // busy from the cycle after an accepted request until the cycle after its done pulse
    always @(posedge clk or posedge reset)
        if (reset) exp_busy <= 1'b0;
        else if (!exp_busy && bus.wr_ps2) exp_busy <= 1'b1;
        else if (bus.tx_done_tick) exp_busy <= 1'b0;

    always @(posedge clk) if (bus.tx_done_tick && !reset) done_cnt <= done_cnt + 1;

    always @(negedge clk) begin
        check("tx_idle", bus.tx_idle, !exp_busy);
        check("tx_err", bus.tx_err, bus.tx_done_tick & exp_err);
        if (!exp_end_ok) check("done_unexpected", bus.tx_done_tick, 0);
        if (bus.tx_done_tick) check("oe_at_done", {bus.ps2c_oe, bus.ps2d_oe}, 0);
        if (bus.ps2c_oe) check("rts_while_idle", bus.tx_idle, 0);
    end

    task automatic do_reset();
        int d0;
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst_c_oe", bus.ps2c_oe, 0);
        check("rst_d_oe", bus.ps2d_oe, 0);
        check("rst_idle", bus.tx_idle, 1);
        check("rst_done", {bus.tx_done_tick, bus.tx_err}, 0);
        dev_c = 1'b1;
        dev_d = 1'b1;
        exp_end_ok = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (100) @(negedge clk);
        check("no_done_after_rst", done_cnt - d0, 0);
    endtask

    // mode: 0 ack, 1 nack, 2 stop after bit 3, 3 glitches, 4 wr during DATA,
    //       5 wr on done cycle, 6 reset in RTS, 7 reset in DATA
    task automatic send(input logic [7:0] b, input int mode);
        logic [10:0] exp_bits;
        int n, t0, d0;
        exp_bits = {1'b1, ~^b, b, 1'b0};
        samp = '0;
        t0 = 0;
        d0 = done_cnt;
        @(negedge clk);
        bus.wr_ps2 = 1'b1;
        bus.din = b;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        bus.din = 8'h00;
        n = 0;
        while (bus.ps2c_oe && n < 200) begin
            n++;
            if (mode == 6 && n == 10) begin
                do_reset();
                return;
            end
            @(negedge clk);
        end
        check("rts_len", n, 50);
        samp[0] = bus.ps2d_in;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_c = 1'b0;
            if (mode == 2 && k == 4) t0 = cyc;
            if (mode == 4 && k == 5) begin
                @(negedge clk);
                bus.wr_ps2 = 1'b1;
                bus.din = 8'hAA;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
                repeat (18) @(negedge clk);
            end else if (mode == 7 && k == 3) begin
                repeat (10) @(negedge clk);
                do_reset();
                return;
            end else if (mode == 3) begin
                repeat (10) @(negedge clk);
                dev_c = 1'b1;
                repeat (3) @(negedge clk);
                dev_c = 1'b0;
                repeat (7) @(negedge clk);
            end else repeat (20) @(negedge clk);
            samp[k] = bus.ps2d_in;
            dev_c = 1'b1;
            if (mode == 3) begin
                repeat (10) @(negedge clk);
                dev_c = 1'b0;
                repeat (3) @(negedge clk);
                dev_c = 1'b1;
                repeat (7) @(negedge clk);
            end else repeat (20) @(negedge clk);
            if (mode == 2 && k == 4) break;
        end
        for (int k = 0; k < 11; k++)
            if (mode != 2 || k <= 4) check($sformatf("bit%0d", k), samp[k], exp_bits[k]);
        if (mode == 2) begin
            exp_err = 1'b1;
            exp_end_ok = 1'b1;
        end else begin
            dev_c = 1'b0;
            repeat (5) @(negedge clk);
            dev_d = (mode == 1);
            repeat (15) @(negedge clk);
            dev_c = 1'b1;
            repeat (20) @(negedge clk);
            dev_c = 1'b0;
            repeat (20) @(negedge clk);
            exp_err = (mode == 1);
            exp_end_ok = 1'b1;
            dev_c = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 5) dev_d = 1'b1;
        end while (!bus.tx_done_tick && n < 3000);
        check("done_seen", bus.tx_done_tick, 1);
        if (mode == 2) check("timeout_window", (cyc - t0 >= 2000) && (cyc - t0 <= 2015), 1);
        else check("done_latency", n <= 15, 1);
        if (mode == 5) begin
            bus.wr_ps2 = 1'b1;
            bus.din = 8'h33;
        end
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        exp_end_ok = 1'b0;
        check("idle_after_done", bus.tx_idle, 1);
        check("one_done", done_cnt - d0, 1);
        if (mode == 4 || mode == 5) begin
            repeat (60) @(negedge clk);
            check("no_extra_rts", bus.ps2c_oe, 0);
            check("still_one_done", done_cnt - d0, 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_ps2 = 1'b0;
        bus.din = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_c_oe", bus.ps2c_oe, 0);
        check("reset_d_oe", bus.ps2d_oe, 0);
        check("reset_idle", bus.tx_idle, 1);
        check("reset_done_err", {bus.tx_done_tick, bus.tx_err}, 0);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        send(8'hED, 0);
        check("frame_ED", samp, 11'h7DA);
        send(8'h01, 0);
        check("parity_01", samp[9], 0);
        send(8'h00, 0);
        check("parity_00", samp[9], 1);
        send(8'h5A, 1);
        send(8'hC3, 2);
        send(8'h55, 4);
        send(8'h3C, 3);
        send(8'h96, 5);
        send(8'h11, 6);
        send(8'hAA, 7);
        send(8'hFF, 0);
        check("frame_FF", samp, 11'h7FE);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
